// File: rtl/duty_ctrl.sv
// duty_ctrl: two-button duty-cycle controller for a PWM stage.
//
// Each raw button is synchronized, debounced, then fed to a small FSM that
// issues a single step request on press, another once the press has been
// held long enough, and further requests at a fixed repeat rate after that.
// The step requests move a saturating 4-bit duty value.
//
// Ports:
//   clk       sole clock, all state on its rising edge
//   rst       asynchronous, active-high reset
//   btn_up    raw push button, high = pressed, requests duty +1
//   btn_dn    raw push button, high = pressed, requests duty -1
//   duty_cyc  registered duty value (0..15), drives the PWM duty input
//   duty_upd  one-cycle pulse in the cycle duty_cyc takes a new value
//   at_limit  registered, high while duty_cyc is 0 or 15
//
// Internal per-button state (index 0 = up, 1 = dn) is kept in the arrays
// state, hold_cnt and rpt_cnt so checkers can bind to it hierarchically.

module duty_ctrl #(
    parameter int DEB_CYCLES  = 500000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int RPT_CYCLES  = 5000000,
    parameter int DUTY_INIT   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic [3:0] duty_cyc,
    output logic       duty_upd,
    output logic       at_limit
);

    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int RW = (RPT_CYCLES  > 1) ? $clog2(RPT_CYCLES)  : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_CYCLES - 1);
    localparam logic [3:0]    INIT_VAL  = 4'(DUTY_INIT);
    localparam logic          INIT_LIM  = (DUTY_INIT == 0) || (DUTY_INIT == 15);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt   [2];
    state_t        state     [2];
    state_t        state_nxt [2];
    logic [HW-1:0] hold_cnt  [2];
    logic [HW-1:0] hold_nxt  [2];
    logic [RW-1:0] rpt_cnt   [2];
    logic [RW-1:0] rpt_nxt   [2];
    logic [1:0]    step;
    logic [3:0]    duty_nxt;

    assign btn_raw = {btn_dn, btn_up};

    // Two-flop synchronizer: the only flops that see the raw buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce: count while the synchronized level disagrees with the
    // debounced level; any agreement clears the count, so a glitch shorter
    // than DEB_CYCLES never reaches the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= 2'b00;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press FSM state and timers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state[i]    <= IDLE;
                hold_cnt[i] <= '0;
                rpt_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state[i]    <= state_nxt[i];
                hold_cnt[i] <= hold_nxt[i];
                rpt_cnt[i]  <= rpt_nxt[i];
            end
        end
    end

    // Next state and step requests. A debounced release always wins over a
    // timer expiring in the same cycle, so letting go never adds a step.
    always_comb begin
        step = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_nxt[i] = state[i];
            hold_nxt[i]  = hold_cnt[i];
            rpt_nxt[i]   = rpt_cnt[i];
            case (state[i])
                IDLE: begin
                    if (deb[i]) begin
                        state_nxt[i] = HELD;
                        step[i]      = 1'b1;
                        hold_nxt[i]  = '0;
                    end
                end
                HELD: begin
                    if (!deb[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (hold_cnt[i] == HOLD_LAST) begin
                        state_nxt[i] = REPEAT;
                        step[i]      = 1'b1;
                        rpt_nxt[i]   = '0;
                    end else begin
                        hold_nxt[i] = hold_cnt[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!deb[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (rpt_cnt[i] == RPT_LAST) begin
                        step[i]    = 1'b1;
                        rpt_nxt[i] = '0;
                    end else begin
                        rpt_nxt[i] = rpt_cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                end
            endcase
        end
    end

    // Saturating step; simultaneous up and down requests cancel.
    always_comb begin
        duty_nxt = duty_cyc;
        if (step[0] && !step[1] && (duty_cyc != 4'd15)) begin
            duty_nxt = duty_cyc + 4'd1;
        end else if (step[1] && !step[0] && (duty_cyc != 4'd0)) begin
            duty_nxt = duty_cyc - 4'd1;
        end
    end

    // Flags are derived from the next value so they line up with duty_cyc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cyc <= INIT_VAL;
            duty_upd <= 1'b0;
            at_limit <= INIT_LIM;
        end else begin
            duty_cyc <= duty_nxt;
            duty_upd <= (duty_nxt != duty_cyc);
            at_limit <= (duty_nxt == 4'd0) || (duty_nxt == 4'd15);
        end
    end

endmodule
